pri_encoder_stream: RTL and testbench

//  Parametrised, handshaked priority encoder. Captures a WIDTH-bit request vector, then emits
//  the index of each set bit, one per output beat, in priority order (ALL_HITS=1), or only the

---
 rtl/pri_encoder_pkg.sv | 19 +
 rtl/pri_encoder_stream_if.sv | 27 ++
 rtl/pri_find_first.sv | 33 +++
 rtl/pri_encoder_stream.sv | 90 +++++++++
 tb/tb_pri_encoder_stream.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pri_encoder_pkg.sv
// Shared types and helpers for the streaming priority encoder.
package pri_encoder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // Constant-evaluable ceil(log2(v)), used to size index fields.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pri_encoder_stream_if.sv
// Request-in / index-out stream bundle for pri_encoder_stream.
interface pri_encoder_stream_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = pri_encoder_pkg::clog2(WIDTH)
) ();

  logic             enable;
  logic [WIDTH-1:0] in_vec;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] out_index;
  logic             out_none;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  enable, in_vec, in_valid, out_ready,
    output in_ready, out_index, out_none, out_last, out_valid
  );

  modport master (
    output enable, in_vec, in_valid, out_ready,
    input  in_ready, out_index, out_none, out_last, out_valid
  );

endinterface

// File: rtl/pri_find_first.sv
// Combinational priority search: winning index, any-set flag and one-hot mask of the winner.
module pri_find_first
  import pri_encoder_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned IDX_W     = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o,
  output logic [WIDTH-1:0] onehot_o
);

  int unsigned b;

  // Walk from lowest to highest priority so the last hit seen is the winner.
  always_comb begin
    idx_o    = '0;
    onehot_o = '0;
    found_o  = |vec_i;
    b        = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      b = MSB_FIRST ? i : (WIDTH - 1 - i);
      if (vec_i[b]) begin
        idx_o       = IDX_W'(b);
        onehot_o    = '0;
        onehot_o[b] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pri_encoder_stream.sv
// Handshaked priority encoder: captures a request vector, then streams the index of each
// set bit (or only the winner) in priority order, with a distinct "none set" beat.
module pri_encoder_stream
  import pri_encoder_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned IDX_W     = clog2(WIDTH),
  parameter bit          MSB_FIRST = 1'b0,
  parameter bit          ALL_HITS  = 1'b1
) (
  input logic                clk,
  input logic                reset,
  pri_encoder_stream_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] residual_q, residual_d;
  logic             zero_q, zero_d;

  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [WIDTH-1:0] win_onehot;
  logic [WIDTH-1:0] capture_vec_c;
  logic             scan_c;
  logic             single_left_c;
  logic             last_c;

  pri_find_first #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST),
    .IDX_W    (IDX_W)
  ) u_find (
    .vec_i   (residual_q),
    .idx_o   (win_idx),
    .found_o (win_found),
    .onehot_o(win_onehot)
  );

  assign capture_vec_c = bus.enable ? bus.in_vec : '0;
  assign scan_c        = (state_q == ST_SCAN);
  assign single_left_c = win_found && ((residual_q & ~win_onehot) == '0);
  assign last_c        = zero_q | !ALL_HITS | single_left_c;

  // Beat outputs come only from registered residual/zero flag; gated to zero outside SCAN.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = scan_c;
  assign bus.out_index = scan_c ? win_idx : '0;
  assign bus.out_none  = scan_c & zero_q;
  assign bus.out_last  = scan_c & last_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      residual_q <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
      zero_q     <= zero_d;
    end
  end

  // Capture in IDLE; retire one winner per accepted beat in SCAN.
  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
    zero_d     = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          residual_d = capture_vec_c;
          zero_d     = (capture_vec_c == '0);
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (bus.out_ready) begin
          residual_d = residual_q & ~win_onehot;
          if (last_c) begin
            state_d    = ST_IDLE;
            residual_d = '0;
            zero_d     = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pri_encoder_stream.sv
// Bench for pri_encoder_stream: four configurations checked against a list-based model.
module tb_pri_encoder_stream;
  import pri_encoder_pkg::*;

  typedef struct {
    int idx;
    bit none;
    bit last;
    int cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] vec;
  logic        en, vld, rdy;
  int          sel;

  always #5 clk = ~clk;

  pri_encoder_stream_if #(.WIDTH(16)) b0 ();
  pri_encoder_stream_if #(.WIDTH(16)) b1 ();
  pri_encoder_stream_if #(.WIDTH(16)) b2 ();
  pri_encoder_stream_if #(.WIDTH(5))  b3 ();

  assign b0.in_vec = vec;       assign b1.in_vec = vec;
  assign b2.in_vec = vec;       assign b3.in_vec = vec[4:0];
  assign b0.enable = en;        assign b1.enable = en;
  assign b2.enable = en;        assign b3.enable = en;
  assign b0.out_ready = rdy;    assign b1.out_ready = rdy;
  assign b2.out_ready = rdy;    assign b3.out_ready = rdy;
  assign b0.in_valid = vld && (sel == 0);
  assign b1.in_valid = vld && (sel == 1);
  assign b2.in_valid = vld && (sel == 2);
  assign b3.in_valid = vld && (sel == 3);

  pri_encoder_stream #(.WIDTH(16), .MSB_FIRST(1'b0), .ALL_HITS(1'b1))
    u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  pri_encoder_stream #(.WIDTH(16), .MSB_FIRST(1'b1), .ALL_HITS(1'b1))
    u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  pri_encoder_stream #(.WIDTH(16), .MSB_FIRST(1'b0), .ALL_HITS(1'b0))
    u2 (.clk(clk), .reset(reset), .bus(b2.slave));
  pri_encoder_stream #(.WIDTH(5), .MSB_FIRST(1'b0), .ALL_HITS(1'b1))
    u3 (.clk(clk), .reset(reset), .bus(b3.slave));

  logic o_valid, o_none, o_last, o_inrdy;
  int   o_idx;

  always_comb begin
    o_valid = b3.out_valid; o_none = b3.out_none; o_last = b3.out_last;
    o_inrdy = b3.in_ready;  o_idx  = int'(b3.out_index);
    case (sel)
      0: begin o_valid = b0.out_valid; o_none = b0.out_none; o_last = b0.out_last;
               o_inrdy = b0.in_ready;  o_idx  = int'(b0.out_index); end
      1: begin o_valid = b1.out_valid; o_none = b1.out_none; o_last = b1.out_last;
               o_inrdy = b1.in_ready;  o_idx  = int'(b1.out_index); end
      2: begin o_valid = b2.out_valid; o_none = b2.out_none; o_last = b2.out_last;
               o_inrdy = b2.in_ready;  o_idx  = int'(b2.out_index); end
      default: ;
    endcase
  end

  int cfg_w[4]   = '{16, 16, 16, 5};
  bit cfg_msb[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  bit cfg_all[4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  beat_t obs_q[$];
  beat_t exp_q[$];
  int    stab_err, inrdy_err, back_cyc;
  bit    timed_out, back_ok;
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: list of set indices in priority order, reduced per configuration.
  function automatic void build_exp(input logic [15:0] v, input bit e, input int s);
    int hits[$];
    int n;
    exp_q.delete();
    for (int i = 0; i < cfg_w[s]; i++) if (e && v[i]) hits.push_back(i);
    if (cfg_msb[s]) hits.reverse();
    if (hits.size() == 0) begin
      exp_q.push_back('{0, 1'b1, 1'b1, 1});
    end else begin
      n = cfg_all[s] ? hits.size() : 1;
      for (int i = 0; i < n; i++) exp_q.push_back('{hits[i], 1'b0, (i == n - 1), i + 1});
    end
  endfunction

  // Offers one vector and collects accepted beats; rmode 0=ready, 1=toggle, 2=random.
  task automatic run_vec(input int s, input logic [15:0] v, input logic e,
                         input int rmode, input bit hold);
    int    cyc;
    bit    r, have_prev, done;
    beat_t p, cur;
    obs_q.delete();
    stab_err = 0; inrdy_err = 0; timed_out = 0; have_prev = 0; done = 0;
    p = '{0, 1'b0, 1'b0, 0};
    sel = s; vec = v; en = e; vld = 1'b1; rdy = 1'b0;
    tick();
    cyc = 1;
    if (hold) begin vec = ~v; en = ~e; end
    else vld = 1'b0;
    while (!done && cyc < 200) begin
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      rdy = r;
      cur = '{o_idx, o_none, o_last, cyc};
      if (o_inrdy) inrdy_err++;
      if (!o_valid) stab_err++;
      if (have_prev && (cur.idx != p.idx || cur.none != p.none || cur.last != p.last))
        stab_err++;
      if (o_valid && r) begin
        obs_q.push_back(cur);
        have_prev = 0;
        if (o_last) begin done = 1; vld = 1'b0; end
      end else if (o_valid) begin
        have_prev = 1;
        p = cur;
      end
      tick();
      cyc++;
    end
    vld = 1'b0; rdy = 1'b0;
    timed_out = !done;
    back_cyc  = cyc;
    back_ok   = o_inrdy && !o_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; vld = 1'b0; rdy = 1'b0; en = 1'b0; vec = '0; sel = 0;
    tick(); tick();
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      n_tests++; if (o_inrdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready dut%0d got=%b exp=1", s, o_inrdy); end
      n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid dut%0d got=%b exp=0", s, o_valid); end
      n_tests++; if (o_idx != 0)       begin n_fail++; $display("FAIL reset_out_index dut%0d got=%0d exp=0", s, o_idx); end
      n_tests++; if (o_none !== 1'b0)  begin n_fail++; $display("FAIL reset_out_none dut%0d got=%b exp=0", s, o_none); end
      n_tests++; if (o_last !== 1'b0)  begin n_fail++; $display("FAIL reset_out_last dut%0d got=%b exp=0", s, o_last); end
    end
    tick();
  endtask

  task automatic test_lsb_stream();
    run_vec(0, 16'h8012, 1'b1, 0, 1'b0);
    build_exp(16'h8012, 1'b1, 0);
    n_tests++; if (timed_out || obs_q.size() != 3) begin n_fail++; $display("FAIL lsb_beats got=%0d exp=3 timeout=%0b", obs_q.size(), timed_out); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] != exp_q[i]) begin
        n_fail++;
        $display("FAIL lsb_beat%0d got idx=%0d none=%0b last=%0b cyc=%0d exp idx=%0d none=%0b last=%0b cyc=%0d",
                 i, obs_q[i].idx, obs_q[i].none, obs_q[i].last, obs_q[i].cyc,
                 exp_q[i].idx, exp_q[i].none, exp_q[i].last, exp_q[i].cyc);
      end
    end
    n_tests++; if (!back_ok || back_cyc != 4) begin n_fail++; $display("FAIL lsb_in_ready_return got cyc=%0d ok=%0b exp cyc=4 ok=1", back_cyc, back_ok); end
    n_tests++; if (inrdy_err != 0) begin n_fail++; $display("FAIL lsb_in_ready_in_scan got=%0d exp=0", inrdy_err); end
  endtask

  task automatic test_msb_backpressure();
    run_vec(1, 16'h8012, 1'b1, 1, 1'b0);
    build_exp(16'h8012, 1'b1, 1);
    n_tests++; if (timed_out || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL msb_beats got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i].idx != exp_q[i].idx || obs_q[i].none != exp_q[i].none || obs_q[i].last != exp_q[i].last) begin
        n_fail++;
        $display("FAIL msb_beat%0d got idx=%0d last=%0b exp idx=%0d last=%0b",
                 i, obs_q[i].idx, obs_q[i].last, exp_q[i].idx, exp_q[i].last);
      end
    end
    n_tests++; if (stab_err != 0) begin n_fail++; $display("FAIL msb_stall_stable got=%0d exp=0", stab_err); end
  endtask

  task automatic test_single_and_none();
    logic [15:0] vv[3] = '{16'h0001, 16'h0000, 16'hFFFF};
    bit          ee[3] = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      run_vec(0, vv[k], ee[k], 0, 1'b0);
      build_exp(vv[k], ee[k], 0);
      n_tests++;
      if (timed_out || obs_q.size() != 1 || obs_q[0].idx != exp_q[0].idx ||
          obs_q[0].none != exp_q[0].none || obs_q[0].last != exp_q[0].last) begin
        n_fail++;
        $display("FAIL single_none%0d got n=%0d idx=%0d none=%0b last=%0b exp n=1 idx=%0d none=%0b last=%0b",
                 k, obs_q.size(), (obs_q.size() > 0) ? obs_q[0].idx : -1,
                 (obs_q.size() > 0) ? obs_q[0].none : 1'b0, (obs_q.size() > 0) ? obs_q[0].last : 1'b0,
                 exp_q[0].idx, exp_q[0].none, exp_q[0].last);
      end
    end
  endtask

  task automatic test_winner_only();
    run_vec(2, 16'hF0F0, 1'b1, 0, 1'b1);
    n_tests++;
    if (timed_out || obs_q.size() != 1 || obs_q[0].idx != 4 || obs_q[0].last != 1'b1) begin
      n_fail++;
      $display("FAIL winner_only got n=%0d idx=%0d exp n=1 idx=4 last=1", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0].idx : -1);
    end
    n_tests++; if (back_cyc != 2 || !back_ok) begin n_fail++; $display("FAIL winner_only_return got cyc=%0d exp=2", back_cyc); end
    tick(); tick();
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL winner_only_no_recapture got=%b exp=0", o_valid); end
  endtask

  task automatic test_reset_mid_scan();
    int acc, g;
    int got[$];
    sel = 0; vec = 16'hFFFF; en = 1'b1; vld = 1'b1; rdy = 1'b1;
    tick();
    vld = 1'b0; acc = 0; g = 0;
    while (acc < 3 && g < 50) begin
      if (o_valid && rdy) begin got.push_back(o_idx); acc++; end
      tick();
      g++;
    end
    n_tests++; if (acc != 3 || got[0] != 0 || got[1] != 1 || got[2] != 2) begin n_fail++; $display("FAIL rst_scan_prefix got n=%0d exp idx 0,1,2", acc); end
    rdy = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_scan_valid got=%b exp=0", o_valid); end
    n_tests++; if (o_inrdy !== 1'b1) begin n_fail++; $display("FAIL rst_scan_in_ready got=%b exp=1", o_inrdy); end
    run_vec(0, 16'h0100, 1'b1, 0, 1'b0);
    n_tests++;
    if (timed_out || obs_q.size() != 1 || obs_q[0].idx != 8 || obs_q[0].last != 1'b1 || obs_q[0].none != 1'b0) begin
      n_fail++;
      $display("FAIL rst_scan_next got n=%0d idx=%0d exp n=1 idx=8", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0].idx : -1);
    end
  endtask

  task automatic test_width5();
    run_vec(3, 16'h0015, 1'b1, 0, 1'b0);
    n_tests++;
    if (timed_out || obs_q.size() != 3 || obs_q[0].idx != 0 || obs_q[1].idx != 2 ||
        obs_q[2].idx != 4 || obs_q[2].last != 1'b1 || obs_q[1].last != 1'b0) begin
      n_fail++;
      $display("FAIL width5_10101 got n=%0d exp idx 0,2,4 last on 4", obs_q.size());
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    bit          e, bad;
    int          s, nv;
    for (int k = 0; k < 10900; k++) begin
      if (k < 10000) begin
        s = 3;
        v = 16'($urandom_range(0, 31));
      end else begin
        s = (k - 10000) % 3;
        v = 16'($urandom & $urandom);
      end
      e = ($urandom_range(0, 7) != 0);
      run_vec(s, v, e, 2, 1'b0);
      build_exp(v, e, s);
      nv  = obs_q.size();
      bad = timed_out || (nv != exp_q.size()) || (stab_err != 0) || (inrdy_err != 0) || !back_ok;
      for (int i = 0; i < nv && i < exp_q.size(); i++)
        if (obs_q[i].idx != exp_q[i].idx || obs_q[i].none != exp_q[i].none ||
            obs_q[i].last != exp_q[i].last) bad = 1;
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL random dut%0d vec=%h en=%0b got beats=%0d exp beats=%0d stall_err=%0d",
                 s, v, e, nv, exp_q.size(), stab_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_stream();
    test_msb_backpressure();
    test_single_and_none();
    test_winner_only();
    test_reset_mid_scan();
    test_width5();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
